// File: rtl/ball_pkg.sv
// Shared definitions for the ball layer arbiter: default transparent colour,
// ball count limit, index type, report FSM states and the pair bit mapping.
package ball_pkg;

  localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;
  localparam int         MAX_BALLS           = 8;
  localparam int         BALL_IDX_W          = $clog2(MAX_BALLS);

  typedef logic [BALL_IDX_W-1:0] ball_idx_t;

  typedef enum logic {IDLE, REPORT} arb_state_e;

  // Bit position of pair (i,j), i<j, in an n-ball upper-triangle matrix.
  // Positions ascend in report order: (0,1),(0,2),...,(0,n-1),(1,2),...
  function automatic int pair_index(input int n, input int i, input int j);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/ball_layer_arbiter_if.sv
// Collision pair handshake between the arbiter (master) and the game-logic
// collision handler (slave).
interface ball_layer_arbiter_if #(
  parameter int IDX_W = 2
);
  logic             pairValid;
  logic             pairReady;
  logic [IDX_W-1:0] pairA;
  logic [IDX_W-1:0] pairB;

  modport master (output pairValid, output pairA, output pairB, input pairReady);
  modport slave  (input pairValid, input pairA, input pairB, output pairReady);
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational first-set finder: searches req starting at bit 'base' and
// wrapping modulo W. Used for the pixel winner and for the pair scan.
module rr_priority_pick #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk W positions from base, keep the first set one
  always_comb begin
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < W; k++) begin
      pos = int'(base) + k;
      if (pos >= W) pos = pos - W;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ball_layer_arbiter.sv
// Per-pixel ball layer arbiter with optional per-frame overlap reporting.
// Build option: define BALL_ARB_COLLISION_EN to include overlap capture, the
// snapshot/report FSM and the pair handshake; otherwise only the pixel
// arbitration is built and the pair outputs are tied low.
module ball_layer_arbiter
  import ball_pkg::*;
#(
  parameter int         NUM_BALLS            = 4,
  parameter logic [7:0] TRANSPARENT_ENCODING = TRANSPARENT_DEFAULT,
  localparam int        IDX_W                = $clog2(NUM_BALLS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      startOfFrame,
  input  logic [NUM_BALLS-1:0]      drawingRequestBalls,
  input  logic [NUM_BALLS-1:0][7:0] RGBBalls,
  input  logic [IDX_W-1:0]          topBall,
  output logic                      drawingRequestBall,
  output logic [7:0]                RGBoutBall,
  output logic [IDX_W-1:0]          winnerIdx,
  ball_layer_arbiter_if.master      pair_bus,
  output logic                      pairOverrun
);

  logic [IDX_W-1:0] top_eff_p0;
  logic             win_found_p0;
  logic [IDX_W-1:0] win_idx_p0;

  assign top_eff_p0 = (int'(topBall) >= NUM_BALLS) ? '0 : topBall;

  rr_priority_pick #(.W(NUM_BALLS), .IW(IDX_W)) u_win_pick (
    .req   (drawingRequestBalls),
    .base  (top_eff_p0),
    .found (win_found_p0),
    .idx   (win_idx_p0)
  );

  // Pixel stage p0 -> registered layer-mux outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drawingRequestBall <= 1'b0;
      RGBoutBall         <= TRANSPARENT_ENCODING;
      winnerIdx          <= '0;
    end else begin
      drawingRequestBall <= win_found_p0;
      RGBoutBall         <= win_found_p0 ? RGBBalls[win_idx_p0] : TRANSPARENT_ENCODING;
      winnerIdx          <= win_found_p0 ? win_idx_p0 : '0;
    end
  end

`ifdef BALL_ARB_COLLISION_EN
  localparam int NP = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  arb_state_e       state;
  logic [NP-1:0]    live_mtx;
  logic [NP-1:0]    snap_mtx;
  logic [PW-1:0]    cur_pos;
  logic [NP-1:0]    frame_pairs_p0;
  logic [NP-1:0]    acc_bit_p0;
  logic [NP-1:0]    snap_next_p0;
  logic             accept_p0;
  logic             nxt_found_p0;
  logic [PW-1:0]    nxt_pos_p0;
  logic [IDX_W-1:0] nxt_a_p0;
  logic [IDX_W-1:0] nxt_b_p0;

  // Pairs of balls drawing on this pixel
  always_comb begin
    frame_pairs_p0 = '0;
    for (int i = 0; i < NUM_BALLS; i++)
      for (int j = i + 1; j < NUM_BALLS; j++)
        frame_pairs_p0[pair_index(NUM_BALLS, i, j)] =
          drawingRequestBalls[i] & drawingRequestBalls[j];
  end

  assign accept_p0 = pair_bus.pairValid & pair_bus.pairReady;

  // Snapshot as it will be after this edge: reloaded at frame start,
  // otherwise minus the pair accepted this cycle
  always_comb begin
    acc_bit_p0 = '0;
    if (accept_p0) acc_bit_p0[cur_pos] = 1'b1;
    snap_next_p0 = startOfFrame ? live_mtx : (snap_mtx & ~acc_bit_p0);
  end

  rr_priority_pick #(.W(NP), .IW(PW)) u_pair_pick (
    .req   (snap_next_p0),
    .base  ('0),
    .found (nxt_found_p0),
    .idx   (nxt_pos_p0)
  );

  // Translate the lowest pending bit position back to its ball indices
  always_comb begin
    nxt_a_p0 = '0;
    nxt_b_p0 = '0;
    for (int i = 0; i < NUM_BALLS; i++)
      for (int j = i + 1; j < NUM_BALLS; j++)
        if (pair_index(NUM_BALLS, i, j) == int'(nxt_pos_p0)) begin
          nxt_a_p0 = IDX_W'(i);
          nxt_b_p0 = IDX_W'(j);
        end
  end

  // Capture/report FSM; pair outputs come from the next snapshot so the
  // first pair is visible the cycle after the loading frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      live_mtx           <= '0;
      snap_mtx           <= '0;
      cur_pos            <= '0;
      pair_bus.pairValid <= 1'b0;
      pair_bus.pairA     <= '0;
      pair_bus.pairB     <= '0;
      pairOverrun        <= 1'b0;
    end else begin
      live_mtx           <= startOfFrame ? frame_pairs_p0 : (live_mtx | frame_pairs_p0);
      snap_mtx           <= snap_next_p0;
      cur_pos            <= nxt_pos_p0;
      pair_bus.pairValid <= nxt_found_p0;
      pair_bus.pairA     <= nxt_found_p0 ? nxt_a_p0 : '0;
      pair_bus.pairB     <= nxt_found_p0 ? nxt_b_p0 : '0;
      case (state)
        IDLE: begin
          state <= nxt_found_p0 ? REPORT : IDLE;
        end
        REPORT: begin
          if (startOfFrame && (|(snap_mtx & ~acc_bit_p0))) pairOverrun <= 1'b1;
          state <= nxt_found_p0 ? REPORT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_ok;
  assign unused_ok          = startOfFrame ^ pair_bus.pairReady;
  assign pair_bus.pairValid = 1'b0;
  assign pair_bus.pairA     = '0;
  assign pair_bus.pairB     = '0;
  assign pairOverrun        = 1'b0;
`endif

endmodule

// File: tb/tb_ball_layer_arbiter.sv
// Bench for ball_layer_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Collision expectations follow
// BALL_ARB_COLLISION_EN; without it the pair outputs must stay low.
module tb_ball_layer_arbiter;
  import ball_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
`ifdef BALL_ARB_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                sof;
  logic [N-1:0]        req;
  logic [N-1:0][7:0]   rgb;
  logic [IW-1:0]       top;
  logic                dreq;
  logic [7:0]          rgb_out;
  logic [IW-1:0]       widx;
  logic                ovr;

  ball_layer_arbiter_if #(.IDX_W(IW)) pair_bus ();

  ball_layer_arbiter #(.NUM_BALLS(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .startOfFrame        (sof),
    .drawingRequestBalls (req),
    .RGBBalls            (rgb),
    .topBall             (top),
    .drawingRequestBall  (dreq),
    .RGBoutBall          (rgb_out),
    .winnerIdx           (widx),
    .pair_bus            (pair_bus),
    .pairOverrun         (ovr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit         live_m [N][N];
  int         q_a[$];
  int         q_b[$];
  bit         m_ovr;
  bit         m_dreq;
  logic [7:0] m_rgb;
  int         m_widx;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) live_m[i][j] = 1'b0;
    m_ovr  = 1'b0;
    m_dreq = 1'b0;
    m_rgb  = 8'hFF;
    m_widx = 0;
  endtask

  // Apply one clock edge of the specification's rules to the model
  task automatic model_edge();
    int t;
    int b;
    bit done;
    t = (int'(top) >= N) ? 0 : int'(top);
    m_dreq = 1'b0;
    m_rgb  = 8'hFF;
    m_widx = 0;
    done   = 1'b0;
    for (int k = 0; k < N; k++) begin
      b = (t + k) % N;
      if (!done && req[b]) begin
        done   = 1'b1;
        m_dreq = 1'b1;
        m_rgb  = rgb[b];
        m_widx = b;
      end
    end
    if (q_a.size() > 0 && pair_bus.pairReady) begin
      void'(q_a.pop_front());
      void'(q_b.pop_front());
    end
    if (sof) begin
      if (q_a.size() > 0) m_ovr = 1'b1;
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++)
          if (live_m[i][j]) begin
            q_a.push_back(i);
            q_b.push_back(j);
            live_m[i][j] = 1'b0;
          end
    end
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (req[i] && req[j]) live_m[i][j] = 1'b1;
  endtask

  task automatic compare(input string ph);
    bit ev;
    ev = COLL && (q_a.size() > 0);
    chk({ph, "_dreq"},   32'(dreq), 32'(m_dreq));
    chk({ph, "_rgb"},    32'(rgb_out), 32'(m_rgb));
    chk({ph, "_widx"},   32'(widx), 32'(m_widx));
    chk({ph, "_pvalid"}, 32'(pair_bus.pairValid), 32'(ev));
    if (ev) begin
      chk({ph, "_pairA"}, 32'(pair_bus.pairA), 32'(q_a[0]));
      chk({ph, "_pairB"}, 32'(pair_bus.pairB), 32'(q_b[0]));
    end
    chk({ph, "_ovr"}, 32'(ovr), 32'(COLL && m_ovr));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare(ph);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [IW-1:0] tb, input logic s, input logic rdy);
    req               = r;
    top               = tb;
    sof               = s;
    pair_bus.pairReady = rdy;
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    #2;
    model_reset();
    compare({ph, "_async"});
    @(posedge clk);
    #1;
    compare({ph, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    rgb = '0;
    model_reset();
    #2;
    compare("reset");
    chk("reset_rgb_const", 32'(rgb_out), 32'h0FF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pixel priority cases
    rgb[0] = 8'h11; rgb[1] = 8'hC0; rgb[2] = 8'hFE; rgb[3] = 8'h33;
    drive(4'b0110, 2'd0, 1'b0, 1'b0);
    cycle("tp1");
    chk("tp1_rgb_const", 32'(rgb_out), 32'h0C0);
    chk("tp1_idx_const", 32'(widx), 32'd1);
    drive(4'b0110, 2'd2, 1'b0, 1'b0);
    cycle("tp2");
    chk("tp2_rgb_const", 32'(rgb_out), 32'h0FE);
    chk("tp2_idx_const", 32'(widx), 32'd2);
    drive(4'b0110, 2'd3, 1'b0, 1'b0);
    cycle("wrap");
    chk("wrap_idx_const", 32'(widx), 32'd1);
    drive(4'b0000, 2'd1, 1'b0, 1'b0);
    cycle("noreq");
    chk("noreq_rgb_const", 32'(rgb_out), 32'h0FF);
    chk("noreq_dreq_const", 32'(dreq), 32'd0);

    // Drain whatever the earlier cycles recorded
    drive(4'b0000, 2'd0, 1'b1, 1'b1);
    cycle("drain_sof");
    drive(4'b0000, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle("drain");

    // Two overlaps in one frame, consumer always ready
    drive(4'b1001, 2'd0, 1'b0, 1'b1); cycle("pr_f");
    drive(4'b0110, 2'd0, 1'b0, 1'b1); cycle("pr_f");
    drive(4'b0000, 2'd0, 1'b0, 1'b1); cycle("pr_f");
    drive(4'b0000, 2'd0, 1'b1, 1'b1); cycle("pr_sof");
    drive(4'b0000, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle("pr_rep");

    // Same frame content, consumer stalls for 5 cycles
    drive(4'b1001, 2'd1, 1'b0, 1'b0); cycle("st_f");
    drive(4'b0110, 2'd1, 1'b0, 1'b0); cycle("st_f");
    drive(4'b0000, 2'd1, 1'b1, 1'b0); cycle("st_sof");
    drive(4'b0000, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle("st_hold");
    drive(4'b0000, 2'd1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle("st_rep");

    // Frame start with (1,2) still pending
    drive(4'b1001, 2'd0, 1'b0, 1'b0); cycle("ov_f");
    drive(4'b0110, 2'd0, 1'b0, 1'b0); cycle("ov_f");
    drive(4'b0000, 2'd0, 1'b1, 1'b0); cycle("ov_sof1");
    drive(4'b0000, 2'd0, 1'b0, 1'b1); cycle("ov_acc");
    drive(4'b0101, 2'd0, 1'b0, 1'b0); cycle("ov_f2");
    drive(4'b0000, 2'd0, 1'b1, 1'b0); cycle("ov_sof2");
    chk("ov_set_const", 32'(ovr), 32'(COLL));
    drive(4'b0000, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle("ov_rep");

    // Reset in the middle of a report clears everything including overrun
    drive(4'b1001, 2'd0, 1'b0, 1'b0); cycle("rs_f");
    drive(4'b0000, 2'd0, 1'b1, 1'b0); cycle("rs_sof");
    drive(4'b0000, 2'd0, 1'b0, 1'b0); cycle("rs_pend");
    do_reset("rs");
    chk("rs_ovr_const", 32'(ovr), 32'd0);
    chk("rs_pvalid_const", 32'(pair_bus.pairValid), 32'd0);
    drive(4'b0000, 2'd0, 1'b0, 1'b1);
    cycle("rs_after");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++) rgb[b] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      else                           req = N'($urandom);
      top               = IW'($urandom);
      sof               = ($urandom_range(0, 19) == 0);
      pair_bus.pairReady = ($urandom_range(0, 3) != 0);
      cycle("rnd");
      if (n == 1500) begin
        do_reset("rnd_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_layer_arbiter.md
# ball_layer_arbiter

Per-pixel arbiter between the ball drawers and the frame-level scheduler of ball-to-ball overlap reports. Each pixel cycle it takes the drawing request and RGB outputs of `NUM_BALLS` ball drawers and selects one winner for the VGA layer mux by programmable priority. Within each frame it records which pairs of balls drew on the same pixel. At frame start it replays those pairs, one at a time, to the game-logic collision handler over a valid/ready handshake.

## Interface
Parameters:
- `NUM_BALLS`, 4, number of ball drawers; legal range 2..8.
- `TRANSPARENT_ENCODING`, 8'hFF, RGB value driven when no ball wins.

Ports:
- `clk` in 1: pixel clock. One clock; every register is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse at the first pixel of each frame.
- `drawingRequestBalls` in `NUM_BALLS`: bit i is the drawing request of ball i.
- `RGBBalls` in `NUM_BALLS`×8: RGB of ball i.
- `topBall` in `$clog2(NUM_BALLS)`: ball given highest priority.
- `drawingRequestBall` out 1: registered; asserted when any request bit is set.
- `RGBoutBall` out 8: registered RGB of the winning ball.
- `winnerIdx` out `$clog2(NUM_BALLS)`: registered index of the winner.
- `pairValid` out 1: collision pair is presented.
- `pairReady` in 1: consumer accepts the presented pair.
- `pairA`, `pairB` out `$clog2(NUM_BALLS)` each: pair indices; `pairA` < `pairB` always.
- `pairOverrun` out 1: sticky; set when pairs were lost. Cleared only by `rst`.

## Operation
Pixel arbitration:
- Winner: the first ball with its request set, searching from `topBall` upward, modulo `NUM_BALLS`.
- With no request set: `drawingRequestBall`=0, `RGBoutBall`=`TRANSPARENT_ENCODING`, `winnerIdx`=0.
- `topBall` ≥ `NUM_BALLS` is treated as 0.

Overlap capture:
- The live pair matrix has one bit per pair i<j: `NUM_BALLS`·(`NUM_BALLS`−1)/2 bits.
- Each cycle, every pair whose two request bits are both set ORs into the live matrix.

State machine: IDLE, REPORT.
- On `startOfFrame`, the live matrix is copied into the snapshot matrix and the live matrix is cleared, in the same cycle.
- The pixel on the `startOfFrame` cycle counts toward the new frame.
- The FSM moves IDLE→REPORT when the copied snapshot is non-zero; otherwise it stays in IDLE.
- REPORT scans pairs in ascending order: (0,1), (0,2), …, (0,N−1), (1,2), …
- REPORT presents the lowest set snapshot bit on `pairA`/`pairB` with `pairValid`=1.
- On `pairValid`&&`pairReady`, that bit clears. The next set pair appears the following cycle.
- REPORT returns to IDLE in the cycle the last set bit is accepted; `pairValid` drops the next cycle.
- `startOfFrame` while in REPORT:
  - Unreported snapshot bits are discarded and `pairOverrun` is set.
  - The snapshot is reloaded from the live matrix.
  - The FSM stays in REPORT if the new snapshot is non-zero, else goes to IDLE.
  - A handshake completing in that same cycle is not counted as lost.
- Once `pairValid` rises, `pairA`/`pairB` are held stable until accepted or until `startOfFrame`.

## Timing
- Pixel path latency is exactly 1 cycle: inputs at cycle t appear on the outputs at t+1.
- The first `pairValid` rises 1 cycle after the `startOfFrame` that loads a non-zero snapshot.
- Throughput: one pair per cycle while `pairReady` is held high.
- `pairValid` does not depend combinationally on `pairReady`.
- Reset values:
  - `drawingRequestBall`=0, `RGBoutBall`=`TRANSPARENT_ENCODING`, `winnerIdx`=0.
  - `pairValid`=0, `pairA`=0, `pairB`=0, `pairOverrun`=0.
  - Both matrices clear; FSM in IDLE.
- `rst` asserted mid-report drops all pairs without setting `pairOverrun`.

## Configuration
- Macro: `BALL_ARB_COLLISION_EN`.
- Defined: overlap capture, both matrices, the FSM and the pair handshake are built as described above.
- Undefined: only the pixel arbitration is built.
  - `pairValid`, `pairA`, `pairB` and `pairOverrun` are tied to 0.
  - `pairReady` and `startOfFrame` are ignored.
  - Pixel-path behaviour and latency are unchanged.

## Structure
- Shared package `ball_pkg`:
  - `TRANSPARENT_ENCODING` default.
  - Maximum ball count constant (8).
  - Ball index typedef.
  - FSM state enum.
  - Pair-index function mapping (i,j) to a bit position, i<j.
- Sub-module `rr_priority_pick`: combinational rotate-from-`topBall` first-set finder. It is instantiated once for the winner and reused, with base 0, for the lowest-set-pair scan.

## Test plan
- Requests 4'b0110, `topBall`=0, RGB1=8'hC0, RGB2=8'hFE → one cycle later `RGBoutBall`=8'hC0, `winnerIdx`=1.
- Same requests with `topBall`=2 → `RGBoutBall`=8'hFE, `winnerIdx`=2.
- Balls 0&3 overlap, then balls 1&2 overlap, in one frame; next `startOfFrame`; `pairReady`=1 → (0,3) then (1,2) on consecutive cycles, then `pairValid`=0.
- Same frame content with `pairReady` held 0 for 5 cycles → (0,3) held stable for all 5 cycles; accepted on the first ready cycle.
- `startOfFrame` arrives with (1,2) still pending → `pairOverrun`=1; the new frame's pairs are reported.
- `rst` pulsed while in REPORT → all outputs return to reset values on the next edge; `pairOverrun` stays 0.
